// File: rtl/pedometer_frontend.sv
// Pedometer front end: averages two-axis samples over a short window and batches queued
// weight writes into single or dual updates, never colliding with a countSteps strobe.
module pedometer_frontend #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned WQ_DEPTH    = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_y,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              countSteps,
  output logic              updateWeight,
  output logic              dualUpdateWeights,
  output logic [ADDR_W-1:0] Addr1,
  output logic [ADDR_W-1:0] Addr2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2
);

  localparam int unsigned Win   = 1 << AVG_LOG2;
  localparam int unsigned SumW  = DATA_W + AVG_LOG2;
  localparam int unsigned FillW = AVG_LOG2 + 1;
  localparam int unsigned PtrW  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(WQ_DEPTH + 1);
  localparam int unsigned AgeW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [FillW-1:0] FillFull = FillW'(Win);
  localparam logic [FillW-1:0] FillLast = FillW'(Win - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(WQ_DEPTH);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [CntW-1:0]  CntTwo   = CntW'(2);
  localparam logic [AgeW-1:0]  AgeMax   = AgeW'(HOLD_CYCLES - 1);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(WQ_DEPTH - 1);

  logic [DATA_W-1:0] win_x_q [Win];
  logic [DATA_W-1:0] win_x_d [Win];
  logic [DATA_W-1:0] win_y_q [Win];
  logic [DATA_W-1:0] win_y_d [Win];
  logic [SumW-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [FillW-1:0]  fill_q, fill_d;

  logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
  logic [ADDR_W-1:0] wq_addr_d [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_d [WQ_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   wq_count_q, wq_count_d;
  logic [AgeW-1:0]   age_q, age_d;

  logic              s_ready_q, s_ready_d, w_ready_q, w_ready_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              count_steps_q, count_steps_d;
  logic              upd_q, upd_d, dual_q, dual_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;

  logic              s_acc, w_push;
  logic [1:0]        pop_n;
  logic [PtrW-1:0]   next_ptr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    win_x_d       = win_x_q;
    win_y_d       = win_y_q;
    sum_x_d       = sum_x_q;
    sum_y_d       = sum_y_q;
    fill_d        = fill_q;
    wq_addr_d     = wq_addr_q;
    wq_data_d     = wq_data_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    age_d         = age_q;
    a_d           = a_q;
    b_d           = b_q;
    count_steps_d = 1'b0;
    upd_d         = 1'b0;
    dual_d        = 1'b0;
    addr1_d       = addr1_q;
    addr2_d       = addr2_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    pop_n         = 2'd0;

    s_acc  = s_valid && s_ready_q;
    w_push = w_valid && w_ready_q;

    if (s_acc) begin
      sum_x_d = sum_x_q + SumW'(s_x) - SumW'(win_x_q[Win-1]);
      sum_y_d = sum_y_q + SumW'(s_y) - SumW'(win_y_q[Win-1]);
      for (int i = 1; i < Win; i++) begin
        win_x_d[i] = win_x_q[i-1];
        win_y_d[i] = win_y_q[i-1];
      end
      win_x_d[0] = s_x;
      win_y_d[0] = s_y;
      if (fill_q != FillFull) fill_d = fill_q + FillW'(1);
      // Strobe only once the window holds a full set of real samples.
      if (fill_q >= FillLast) begin
        count_steps_d = 1'b1;
        a_d = sum_x_d[SumW-1:AVG_LOG2];
        b_d = sum_y_d[SumW-1:AVG_LOG2];
      end
    end

    next_ptr = ptr_inc(rd_ptr_q);
    if (!count_steps_d) begin
      if (wq_count_q >= CntTwo) begin
        pop_n = 2'd2;
        // Same address twice: only the later value matters.
        if (wq_addr_q[rd_ptr_q] == wq_addr_q[next_ptr]) begin
          upd_d   = 1'b1;
          addr1_d = wq_addr_q[next_ptr];
          data1_d = wq_data_q[next_ptr];
          addr2_d = '0;
          data2_d = '0;
        end else begin
          dual_d  = 1'b1;
          addr1_d = wq_addr_q[rd_ptr_q];
          data1_d = wq_data_q[rd_ptr_q];
          addr2_d = wq_addr_q[next_ptr];
          data2_d = wq_data_q[next_ptr];
        end
      end else if (wq_count_q == CntOne && age_q == AgeMax) begin
        pop_n   = 2'd1;
        upd_d   = 1'b1;
        addr1_d = wq_addr_q[rd_ptr_q];
        data1_d = wq_data_q[rd_ptr_q];
        addr2_d = '0;
        data2_d = '0;
      end
    end

    case (pop_n)
      2'd1:    rd_ptr_d = next_ptr;
      2'd2:    rd_ptr_d = ptr_inc(next_ptr);
      default: rd_ptr_d = rd_ptr_q;
    endcase

    if (w_push) begin
      wq_addr_d[wr_ptr_q] = w_addr;
      wq_data_d[wr_ptr_q] = w_data;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end

    wq_count_d = wq_count_q + CntW'(w_push) - CntW'(pop_n);

    // Age tracks how long a lone entry has waited; it saturates while issue is blocked.
    if (pop_n != 2'd0 || wq_count_d != CntOne) begin
      age_d = '0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + AgeW'(1);
    end

    s_ready_d = (wq_count_d != CntFull);
    w_ready_d = (wq_count_d < CntFull);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Win; i++) begin
        win_x_q[i] <= '0;
        win_y_q[i] <= '0;
      end
      for (int i = 0; i < WQ_DEPTH; i++) begin
        wq_addr_q[i] <= '0;
        wq_data_q[i] <= '0;
      end
      sum_x_q       <= '0;
      sum_y_q       <= '0;
      fill_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      wq_count_q    <= '0;
      age_q         <= '0;
      s_ready_q     <= 1'b0;
      w_ready_q     <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      count_steps_q <= 1'b0;
      upd_q         <= 1'b0;
      dual_q        <= 1'b0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
    end else begin
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
      wq_addr_q     <= wq_addr_d;
      wq_data_q     <= wq_data_d;
      sum_x_q       <= sum_x_d;
      sum_y_q       <= sum_y_d;
      fill_q        <= fill_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      wq_count_q    <= wq_count_d;
      age_q         <= age_d;
      s_ready_q     <= s_ready_d;
      w_ready_q     <= w_ready_d;
      a_q           <= a_d;
      b_q           <= b_d;
      count_steps_q <= count_steps_d;
      upd_q         <= upd_d;
      dual_q        <= dual_d;
      addr1_q       <= addr1_d;
      addr2_q       <= addr2_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
    end
  end

  assign s_ready           = s_ready_q;
  assign w_ready           = w_ready_q;
  assign A                 = a_q;
  assign B                 = b_q;
  assign countSteps        = count_steps_q;
  assign updateWeight      = upd_q;
  assign dualUpdateWeights = dual_q;
  assign Addr1             = addr1_q;
  assign Addr2             = addr2_q;
  assign Data1             = data1_q;
  assign Data2             = data2_q;

endmodule

// File: tb/tb_pedometer_frontend.sv
// Bench for pedometer_frontend: fixed vector table, hand-written corner sequences, then
// random traffic compared against a queue-based reference model.
module tb_pedometer_frontend;

  localparam int HOLD = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0, w_valid = 1'b0;
  logic [7:0] s_x = '0, s_y = '0, w_data = '0;
  logic [2:0] w_addr = '0;
  logic       s_ready, w_ready, countSteps, updateWeight, dualUpdateWeights;
  logic [7:0] A, B, Data1, Data2;
  logic [2:0] Addr1, Addr2;

  always #5 clk = ~clk;

  pedometer_frontend dut (
    .clk              (clk),
    .reset            (reset),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_x              (s_x),
    .s_y              (s_y),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .w_addr           (w_addr),
    .w_data           (w_data),
    .A                (A),
    .B                (B),
    .countSteps       (countSteps),
    .updateWeight     (updateWeight),
    .dualUpdateWeights(dualUpdateWeights),
    .Addr1            (Addr1),
    .Addr2            (Addr2),
    .Data1            (Data1),
    .Data2            (Data2)
  );

  typedef logic [42:0] vec_t;

  int errors = 0;
  int checks = 0;

  function automatic vec_t pk(input logic cs, input logic upd, input logic dual,
                              input logic sr, input logic wr, input logic [7:0] a,
                              input logic [7:0] b, input logic [2:0] a1, input logic [7:0] d1,
                              input logic [2:0] a2, input logic [7:0] d2);
    return {cs, upd, dual, sr, wr, a, b, a1, d1, a2, d2};
  endfunction

  function automatic vec_t dut_vec();
    return pk(countSteps, updateWeight, dualUpdateWeights, s_ready, w_ready, A, B,
              Addr1, Data1, Addr2, Data2);
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cs,upd,dual,srdy,wrdy,A,B,A1,D1,A2,D2)",
               name, got, exp);
    end
  endtask

  // Reference model: sample history, weight queue and lone-entry wait time.
  typedef struct {int a; int d;} went_t;
  int    m_wx[$];
  int    m_wy[$];
  went_t m_q[$];
  int    m_acc_n, m_age;
  int    m_cs, m_upd, m_dual, m_srdy, m_wrdy, m_A, m_B, m_a1, m_d1, m_a2, m_d2;

  function automatic vec_t model_vec();
    return pk(1'(m_cs), 1'(m_upd), 1'(m_dual), 1'(m_srdy), 1'(m_wrdy), 8'(m_A), 8'(m_B),
              3'(m_a1), 8'(m_d1), 3'(m_a2), 8'(m_d2));
  endfunction

  task automatic model_reset();
    m_wx.delete(); m_wy.delete(); m_q.delete();
    m_acc_n = 0; m_age = 0;
    m_cs = 0; m_upd = 0; m_dual = 0; m_srdy = 0; m_wrdy = 0;
    m_A = 0; m_B = 0; m_a1 = 0; m_d1 = 0; m_a2 = 0; m_d2 = 0;
  endtask

  task automatic model_step();
    bit acc, psh;
    int npop, sx, sy;
    went_t e;
    acc = s_valid && (m_srdy != 0);
    psh = w_valid && (m_wrdy != 0);
    npop = 0;
    m_cs = 0; m_upd = 0; m_dual = 0;
    if (acc) begin
      m_wx.push_back(int'(s_x));
      m_wy.push_back(int'(s_y));
      if (m_wx.size() > 4) begin
        void'(m_wx.pop_front());
        void'(m_wy.pop_front());
      end
      m_acc_n++;
      if (m_acc_n >= 4) begin
        sx = 0; sy = 0;
        foreach (m_wx[i]) begin
          sx += m_wx[i];
          sy += m_wy[i];
        end
        m_cs = 1; m_A = sx / 4; m_B = sy / 4;
      end
    end
    if (m_cs == 0) begin
      if (m_q.size() >= 2) begin
        npop = 2;
        if (m_q[0].a == m_q[1].a) begin
          m_upd = 1; m_a1 = m_q[1].a; m_d1 = m_q[1].d; m_a2 = 0; m_d2 = 0;
        end else begin
          m_dual = 1; m_a1 = m_q[0].a; m_d1 = m_q[0].d; m_a2 = m_q[1].a; m_d2 = m_q[1].d;
        end
      end else if (m_q.size() == 1 && m_age == HOLD - 1) begin
        npop = 1;
        m_upd = 1; m_a1 = m_q[0].a; m_d1 = m_q[0].d; m_a2 = 0; m_d2 = 0;
      end
    end
    repeat (npop) void'(m_q.pop_front());
    if (psh) begin
      e.a = int'(w_addr); e.d = int'(w_data);
      m_q.push_back(e);
    end
    if (npop != 0 || m_q.size() != 1) m_age = 0;
    else if (m_age < HOLD - 1) m_age++;
    m_srdy = (m_q.size() != DEPTH) ? 1 : 0;
    m_wrdy = (m_q.size() < DEPTH) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_zero", dut_vec(), '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic drive(input int sv, input int x, input int y, input int wv, input int wa,
                       input int wd);
    s_valid = 1'(sv); s_x = 8'(x); s_y = 8'(y);
    w_valid = 1'(wv); w_addr = 3'(wa); w_data = 8'(wd);
  endtask

  typedef struct {
    int sv, x, y, wv, wa, wd;
    int cs, upd, dual, sr, wr, ea, eb, a1, d1, a2, d2;
  } row_t;

  row_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Each row: inputs before an edge, expected outputs just after it.
    tbl.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1, 30, 10, 0, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 30, 10, 0, 0, 0,  1, 0, 0, 1, 1,  30, 10, 0, 0, 0, 0});
    tbl.push_back('{1, 10, 20, 0, 0, 0,  1, 0, 0, 1, 1,  25, 12, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,    1, 0, 0, 1, 1,  17, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 5,    0, 0, 0, 1, 1,  17, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 2, 6,    0, 0, 0, 1, 1,  17, 10, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1,  17, 10, 1, 5, 2, 6});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 1, 5, 2, 6});
    tbl.push_back('{0, 0, 0, 1, 1, 5,    0, 0, 0, 1, 1,  17, 10, 1, 5, 2, 6});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 1, 5, 2, 6});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 1, 5, 2, 6});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 1, 0, 1, 1,  17, 10, 1, 5, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 1, 5, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 3, 7,    0, 0, 0, 1, 1,  17, 10, 1, 5, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 3, 9,    0, 0, 0, 1, 1,  17, 10, 1, 5, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 1, 0, 1, 1,  17, 10, 3, 9, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1,  17, 10, 3, 9, 0, 0});

    @(posedge clk);
    #1;
    apply_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].sv, tbl[i].x, tbl[i].y, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      tick();
      check($sformatf("vec%0d", i), dut_vec(),
            pk(1'(tbl[i].cs), 1'(tbl[i].upd), 1'(tbl[i].dual), 1'(tbl[i].sr),
               1'(tbl[i].wr), 8'(tbl[i].ea), 8'(tbl[i].eb), 3'(tbl[i].a1), 8'(tbl[i].d1),
               3'(tbl[i].a2), 8'(tbl[i].d2)));
    end

    // Streaming samples while four weights arrive: queue fills, forcing a sample gap.
    for (int i = 0; i < 4; i++) begin
      drive(1, 40 + i, 50 + i, 1, (i < 2) ? i + 1 : i + 3, 11 * (i + 1));
      tick();
      check($sformatf("stream_cs%0d", i), {countSteps, updateWeight, dualUpdateWeights},
            vec_t'(3'b100));
    end
    check("queue_full_ready", {s_ready, w_ready}, '0);
    drive(1, 60, 70, 0, 0, 0);
    tick();
    check("gap_dual", {countSteps, updateWeight, dualUpdateWeights, Addr1, Data1, Addr2, Data2},
          {3'b001, 3'd1, 8'd11, 3'd2, 8'd22});
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("resume_cs%0d", i), {countSteps, updateWeight, dualUpdateWeights},
            vec_t'(3'b100));
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("drain_dual", {countSteps, updateWeight, dualUpdateWeights, Addr1, Data1, Addr2, Data2},
          {3'b001, 3'd5, 8'd33, 3'd6, 8'd44});

    // Lone entry discarded by reset before it can issue.
    drive(0, 0, 0, 1, 4, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), dut_vec(),
            pk(0, 0, 0, 1, 1, 8'd0, 8'd0, 3'd0, 8'd0, 3'd0, 8'd0));
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      drive(($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), ($urandom_range(0, 9) < 4) ? 1 : 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      tick();
      check("random", dut_vec(), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
